// File: rtl/ros2_arb_pkg.sv
// Shared types and constants for the resource arbiter.
package ros2_arb_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/ros2_arb_pick.sv
// Rotating first-set picker: returns the first set bit of vec_i at or after start_i (wrapping).
module ros2_arb_pick #(
  parameter int N_REQ = 2,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] vec_i,
  input  logic [IW-1:0]    start_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic             valid_o
);

  logic          found;
  logic [IW-1:0] k;

  always_comb begin
    onehot_o = '0;
    found    = 1'b0;
    k        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = IW'((int'(start_i) + i) % N_REQ);
      if (!found && vec_i[k]) begin
        onehot_o[k] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign valid_o = |vec_i;

endmodule

// File: rtl/ros2_res_arbiter.sv
// Single-resource arbiter (fixed priority or round-robin) with latched pending requests.
// Optional hold timeout with forced release is enabled by defining ROS2_ARB_TIMEOUT_EN.
module ros2_res_arbiter
  import ros2_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int RR_MODE = 0,
  parameter int TMO_W   = 16
) (
  input  logic                     clk_int,
  input  logic                     rst_int,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         rel,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic [N_REQ-1:0]         pend
`ifdef ROS2_ARB_TIMEOUT_EN
  ,
  input  logic [TMO_W-1:0]         tmo_cfg,
  output logic                     tmo_evt
`endif
);

  localparam int OW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TMO_W < 1 ||
      (RR_MODE != ARB_FIXED && RR_MODE != ARB_RR)) begin : g_param_err
    $error("ros2_res_arbiter: illegal parameter combination");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0] pick_vec, pick_oh;
  logic             pick_vld;
  logic [OW-1:0]    pick_idx, pick_start;
  logic             rel_own, tmo_hit;

  assign pick_vec   = pend_q | req;
  assign pick_start = (RR_MODE == ARB_RR) ? rr_ptr_q : '0;
  assign rel_own    = rel[owner_q];

  ros2_arb_pick #(.N_REQ(N_REQ)) u_pick (
    .vec_i    (pick_vec),
    .start_i  (pick_start),
    .onehot_o (pick_oh),
    .valid_o  (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) pick_idx = OW'(i);
    end
  end

  // Requests always latch; only the winner of a fresh grant is consumed.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    pend_d   = pend_q | req;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d  = ST_GRANTED;
          grant_d  = pick_oh;
          owner_d  = pick_idx;
          rr_ptr_d = OW'((int'(pick_idx) + 1) % N_REQ);
          pend_d   = (pend_q | req) & ~pick_oh;
        end
      end
      ST_GRANTED: begin
        if (rel_own || tmo_hit) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      pend_q   <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      pend_q   <= pend_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef ROS2_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             evt_q, evt_d;

  // cnt_inc is the number of cycles held including the current one.
  assign cnt_inc = cnt_q + 1'b1;
  assign tmo_hit = (state_q == ST_GRANTED) && (tmo_cfg != '0) && (cnt_inc == tmo_cfg);
  assign evt_d   = tmo_hit && !rel_own;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && pick_vld) cnt_d = '0;
    else if (state_q == ST_GRANTED)     cnt_d = cnt_inc;
  end

  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      cnt_q <= '0;
      evt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      evt_q <= evt_d;
    end
  end

  assign tmo_evt = evt_q;
`else
  assign tmo_hit = 1'b0;
`endif

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = |grant_q;
  assign pend  = pend_q;

endmodule

// File: doc/ros2_res_arbiter.md
ROS2_RES_ARBITER -- requirements
Module: ros2_res_arbiter

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high, named clk_int and rst_int.
REQ-002 Parameter N_REQ, default 2, SHALL set the requester count (2..8).
REQ-003 Parameter RR_MODE, default 0, SHALL select arbitration: 0 fixed priority (index 0 highest), 1 round-robin.
REQ-004 Parameter TMO_W, default 16, SHALL set the timeout counter width.
REQ-005 Port list SHALL be, clock and reset first:
- clk_int  in  1  clock
- rst_int  in  1  sync active-high reset
- req  in  N_REQ  per-requester request, 1-cycle pulse or level
- rel  in  N_REQ  per-requester release pulse
- grant  out  N_REQ  registered one-hot grant, all-zero when idle
- owner  out  clog2(N_REQ)  index of current holder, valid while busy
- busy  out  1  resource held
- pend  out  N_REQ  latched pending requests
- tmo_cfg  in  TMO_W  hold limit in cycles, 0 = unlimited (ARB_TIMEOUT_EN only)
- tmo_evt  out  1  1-cycle forced-release pulse (ARB_TIMEOUT_EN only)

Function
REQ-006 The block SHALL implement states IDLE and GRANTED.
REQ-007 Any req bit asserted in any state SHALL set the matching pend bit on the next edge.
REQ-008 In IDLE with (pend | req) nonzero, the block SHALL enter GRANTED next cycle with exactly one grant bit set and clear that requester's pend bit.
REQ-009 Fixed mode SHALL pick the lowest set index; round-robin SHALL pick the first set index at or after last_owner+1, modulo N_REQ.
REQ-010 In GRANTED, rel from the owner SHALL return to IDLE next cycle with grant all-zero; rel from non-owners SHALL be ignored.
REQ-011 A released resource SHALL stay idle for exactly one cycle before the next grant (minimum rel-to-grant latency 2 cycles).
REQ-012 Owner req and rel in the same cycle: release SHALL take effect and the req SHALL be latched in pend.
REQ-013 req from the current owner while GRANTED, without rel, SHALL be latched in pend.
REQ-014 rel in IDLE SHALL have no effect.
REQ-015 busy SHALL equal |grant; owner SHALL hold its last value while idle.

Reset
REQ-016 rst_int SHALL force IDLE, grant=0, pend=0, owner=0, busy=0, tmo_evt=0, timeout counter=0, and round-robin pointer so that index 0 is searched first.
REQ-017 Reset asserted mid-grant SHALL drop grant the next edge without any tmo_evt.

Configuration
REQ-018 With macro ROS2_ARB_TIMEOUT_EN defined, a counter SHALL clear on grant, increment each GRANTED cycle, and, when it equals nonzero tmo_cfg, force release identical to REQ-010 and pulse tmo_evt for one cycle.
REQ-019 Owner rel coinciding with the timeout cycle SHALL count as a normal release with no tmo_evt.
REQ-020 Without ROS2_ARB_TIMEOUT_EN, tmo_cfg and tmo_evt SHALL be absent and holds SHALL be unlimited.

Structure
REQ-021 Package ros2_arb_pkg SHALL hold the state enumeration and RR_MODE constants ARB_FIXED, ARB_RR.
REQ-022 The pick logic SHALL be one sub-module, ros2_arb_pick (pend vector, start index -> one-hot, valid).

Verification
REQ-023 Bench SHALL cover, N_REQ=4 unless stated:
- Fixed mode, req=4'b1010 in IDLE -> grant=4'b0010 next cycle, pend=4'b1000.
- RR mode, owner 1 releases, pend=4'b0011 -> one idle cycle, then grant=4'b0001.
- N_REQ=2, req pulse from index 1 while index 0 holds -> pend[1]=1; after rel[0], grant=2'b10 two cycles later.
- Non-owner rel[2] while owner=0 -> grant unchanged; owner rel[0]+req[0] same cycle -> IDLE, pend[0]=1.
- Timeout build, tmo_cfg=5, no rel -> grant drops after 5 held cycles, tmo_evt high one cycle; tmo_cfg=0 -> holds 1000 cycles.
- rst_int asserted while grant=4'b0100 -> grant=0, pend=0, tmo_evt=0 next edge.
